// File: rtl/pulse_meas.sv
// pulse_meas: measures high time and rising-to-rising period of an asynchronous pulse train.
module pulse_meas #(
    parameter int CNT_W       = 12,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             PULSE_IN,
    output logic [CNT_W-1:0] HIGH_COUNT,
    output logic [CNT_W-1:0] PERIOD_COUNT,
    output logic             VALID,
    output logic             TIMEOUT
);
    typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    state_t state, state_nx;
    logic s1, s2, s3;
    logic rise, fall, expired, pub, to_set, to_clr;
    logic [CNT_W-1:0] per_cnt, hi_cnt, per_nx, hi_nx, per_inc, hi_inc;
    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + ONE;
    assign hi_inc  = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + ONE;
    // a rise arriving on the timeout cycle still completes the period
    assign expired = (per_cnt == TO_CNT) && !rise;
    always_comb begin
        state_nx = state;
        per_nx   = per_cnt;
        hi_nx    = hi_cnt;
        pub      = 1'b0;
        to_set   = 1'b0;
        to_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = MEAS_HIGH;
                    per_nx   = ONE;
                    hi_nx    = ONE;
                    to_clr   = 1'b1;
                end
            end
            MEAS_HIGH: begin
                if (expired) begin
                    state_nx = IDLE;
                    to_set   = 1'b1;
                end else begin
                    per_nx   = per_inc;
                    hi_nx    = fall ? hi_cnt : hi_inc;
                    state_nx = fall ? MEAS_LOW : MEAS_HIGH;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    pub      = 1'b1;
                    per_nx   = ONE;
                    hi_nx    = ONE;
                    state_nx = MEAS_HIGH;
                end else if (expired) begin
                    state_nx = IDLE;
                    to_set   = 1'b1;
                end else begin
                    per_nx = per_inc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            state        <= IDLE;
            per_cnt      <= '0;
            hi_cnt       <= '0;
            HIGH_COUNT   <= '0;
            PERIOD_COUNT <= '0;
            VALID        <= 1'b0;
            TIMEOUT      <= 1'b0;
        end else begin
            s1      <= PULSE_IN;
            s2      <= s1;
            s3      <= s2;
            state   <= state_nx;
            per_cnt <= per_nx;
            hi_cnt  <= hi_nx;
            VALID   <= pub;
            TIMEOUT <= to_set | (TIMEOUT & ~to_clr);
            if (pub) begin
                HIGH_COUNT   <= hi_cnt;
                PERIOD_COUNT <= per_cnt;
            end
        end
    end
endmodule
